// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: req/ack bus handshake, pipeline stall, load extension and watchdog.
// Optional misalignment trap enabled by defining ALIGN_CHECK_EN.
module mem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exmem_mem_r,
  input  logic        exmem_mem_w,
  input  logic [31:0] exmem_alu_res,
  input  logic [31:0] exmem_rt_data,
  input  logic [3:0]  mem_byte_w_en,
  input  logic [2:0]  exmem_load_sel,
  input  logic [2:0]  exmem_store_sel,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  output logic        mem_stall,
  output logic [31:0] load_data,
  output logic        bus_err,
  output logic        addr_err
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          state;
  logic [TO_W-1:0] cnt;
  logic [2:0]      lsel;
  logic [1:0]      sh;
  logic            is_rd;
  logic            addr_err_q;
  logic            acc;
  logic            misalign;

  assign acc       = exmem_mem_r | exmem_mem_w;
  assign mem_stall = acc & (state != DONE);
  assign addr_err  = addr_err_q;

`ifdef ALIGN_CHECK_EN
  // Store type decides when both strobes are set, matching write-wins priority.
  always_comb begin
    misalign = 1'b0;
    if (exmem_mem_w) begin
      case (exmem_store_sel)
        3'b010:  misalign = 1'b0;
        3'b001:  misalign = exmem_alu_res[0];
        default: misalign = |exmem_alu_res[1:0];
      endcase
    end else begin
      case (exmem_load_sel)
        3'b011, 3'b100: misalign = 1'b0;
        3'b001, 3'b010: misalign = exmem_alu_res[0];
        default:        misalign = |exmem_alu_res[1:0];
      endcase
    end
  end
`else
  assign misalign = 1'b0;
  logic unused_store_sel;
  assign unused_store_sel = ^exmem_store_sel;
`endif

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] sel,
                                         input logic [1:0] s);
    logic [15:0] h;
    logic [7:0]  b;
    h = s[1] ? w[31:16] : w[15:0];
    b = w[{s, 3'b000} +: 8];
    case (sel)
      3'b001:  extend = {{16{h[15]}}, h};
      3'b010:  extend = {16'h0000, h};
      3'b011:  extend = {{24{b[7]}}, b};
      3'b100:  extend = {24'h000000, b};
      default: extend = w;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= '0;
      load_data  <= '0;
      bus_err    <= 1'b0;
      addr_err_q <= 1'b0;
      cnt        <= '0;
      lsel       <= '0;
      sh         <= '0;
      is_rd      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (acc) begin
          dmem_addr  <= {exmem_alu_res[31:2], 2'b00};
          dmem_wdata <= exmem_rt_data;
          dmem_be    <= exmem_mem_w ? mem_byte_w_en : 4'hF;
          dmem_we    <= exmem_mem_w & ~misalign;
          lsel       <= exmem_load_sel;
          sh         <= exmem_alu_res[1:0];
          is_rd      <= ~exmem_mem_w;
          cnt        <= '0;
          bus_err    <= 1'b0;
          if (misalign) begin
            addr_err_q <= 1'b1;
            load_data  <= '0;
            state      <= DONE;
          end else begin
            addr_err_q <= 1'b0;
            dmem_req   <= 1'b1;
            state      <= WAIT;
          end
        end
        WAIT: begin
          // An ack on the limit cycle takes priority over the timeout.
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            if (is_rd) load_data <= extend(dmem_rdata, lsel, sh);
            state <= DONE;
          end else if (cnt == TO_LIM) begin
            dmem_req  <= 1'b0;
            dmem_we   <= 1'b0;
            bus_err   <= 1'b1;
            load_data <= '0;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          bus_err    <= 1'b0;
          addr_err_q <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed scoreboard bench for mem_access_ctrl (watchdog shortened to 4 cycles).
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        exmem_mem_r, exmem_mem_w;
  logic [31:0] exmem_alu_res, exmem_rt_data;
  logic [3:0]  mem_byte_w_en;
  logic [2:0]  exmem_load_sel, exmem_store_sel;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        dmem_req, dmem_we, mem_stall, bus_err, addr_err;
  logic [31:0] dmem_addr, dmem_wdata, load_data;
  logic [3:0]  dmem_be;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] load;
    logic        berr;
    logic        aerr;
    int          stalls;
  } exp_t;

  exp_t sb[$];

  mem_access_ctrl #(.TIMEOUT_CYCLES(4), .TO_W(8)) dut (
    .clk(clk), .reset(reset),
    .exmem_mem_r(exmem_mem_r), .exmem_mem_w(exmem_mem_w),
    .exmem_alu_res(exmem_alu_res), .exmem_rt_data(exmem_rt_data),
    .mem_byte_w_en(mem_byte_w_en), .exmem_load_sel(exmem_load_sel),
    .exmem_store_sel(exmem_store_sel), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .mem_stall(mem_stall),
    .load_data(load_data), .bus_err(bus_err), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one access on a falling edge, acks on WAIT cycle ack_at (0 = never),
  // then compares the DONE-cycle outputs against the queued expectation.
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be,
                        input logic [2:0] lsel, input logic [2:0] ssel,
                        input int ack_at, input logic [31:0] rdata,
                        input logic exp_req, input logic [31:0] exp_load,
                        input logic exp_berr, input logic exp_aerr, input int exp_stalls);
    exp_t e;
    int   stalls;
    bit   done;
    e.req = exp_req; e.we = wr; e.addr = {addr[31:2], 2'b00}; e.wdata = wd;
    e.be = wr ? be : 4'hF; e.load = exp_load; e.berr = exp_berr; e.aerr = exp_aerr;
    e.stalls = exp_stalls;
    sb.push_back(e);
    @(negedge clk);
    exmem_mem_r = rd; exmem_mem_w = wr; exmem_alu_res = addr; exmem_rt_data = wd;
    mem_byte_w_en = be; exmem_load_sel = lsel; exmem_store_sel = ssel;
    #1 stalls = mem_stall ? 1 : 0;
    done = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        chk({tag, ".req"}, 32'(dmem_req), 32'(sb[0].req));
        if (sb[0].req) begin
          chk({tag, ".we"},   32'(dmem_we), 32'(sb[0].we));
          chk({tag, ".addr"}, dmem_addr, sb[0].addr);
          chk({tag, ".be"},   32'(dmem_be), 32'(sb[0].be));
          if (sb[0].we) chk({tag, ".wdata"}, dmem_wdata, sb[0].wdata);
        end
      end
      @(negedge clk);
      if (!mem_stall) begin
        done = 1'b1;
        break;
      end
      stalls++;
      dmem_ack   = (i == ack_at);
      dmem_rdata = rdata;
    end
    dmem_ack = 1'b0;
    e = sb.pop_front();
    chk({tag, ".done"},   32'(done), 32'd1);
    chk({tag, ".stalls"}, 32'(stalls), 32'(e.stalls));
    chk({tag, ".load"},   load_data, e.load);
    chk({tag, ".berr"},   32'(bus_err), 32'(e.berr));
    chk({tag, ".aerr"},   32'(addr_err), 32'(e.aerr));
    chk({tag, ".reqlow"}, 32'(dmem_req), 32'd0);
    exmem_mem_r = 1'b0; exmem_mem_w = 1'b0;
    if (e.berr || e.aerr) begin
      @(posedge clk); #1;
      chk({tag, ".berr_clr"}, 32'(bus_err), 32'd0);
      chk({tag, ".aerr_clr"}, 32'(addr_err), 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1;
    exmem_mem_r = 0; exmem_mem_w = 0; exmem_alu_res = 0; exmem_rt_data = 0;
    mem_byte_w_en = 0; exmem_load_sel = 0; exmem_store_sel = 0;
    dmem_rdata = 0; dmem_ack = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.req",   32'(dmem_req), 32'd0);
    chk("rst.we",    32'(dmem_we), 32'd0);
    chk("rst.addr",  dmem_addr, 32'd0);
    chk("rst.wdata", dmem_wdata, 32'd0);
    chk("rst.be",    32'(dmem_be), 32'd0);
    chk("rst.load",  load_data, 32'd0);
    chk("rst.berr",  32'(bus_err), 32'd0);
    chk("rst.aerr",  32'(addr_err), 32'd0);
    chk("rst.stall", 32'(mem_stall), 32'd0);
    @(negedge clk) reset = 1'b0;

    //     tag    rd wr addr          wdata         be     lsel    ssel  ack rdata         req load          be ae st
    access("lw",  1, 0, 32'h100, 32'h0, 4'h0, 3'b000, 3'b000, 1, 32'hDEADBEEF, 1, 32'hDEADBEEF, 0, 0, 2);
    access("lb",  1, 0, 32'h103, 32'h0, 4'h0, 3'b011, 3'b000, 1, 32'h80FFFF12, 1, 32'hFFFFFF80, 0, 0, 2);
    access("lbu", 1, 0, 32'h103, 32'h0, 4'h0, 3'b100, 3'b000, 2, 32'h80FFFF12, 1, 32'h00000080, 0, 0, 3);
    access("lh",  1, 0, 32'h102, 32'h0, 4'h0, 3'b001, 3'b000, 1, 32'h80FFFF12, 1, 32'hFFFF80FF, 0, 0, 2);
    access("lhu", 1, 0, 32'h102, 32'h0, 4'h0, 3'b010, 3'b000, 1, 32'h80FFFF12, 1, 32'h000080FF, 0, 0, 2);
    access("lh0", 1, 0, 32'h100, 32'h0, 4'h0, 3'b001, 3'b000, 1, 32'h80FFFF12, 1, 32'hFFFFFF12, 0, 0, 2);
    access("sb",  0, 1, 32'h201, 32'h0000AB00, 4'b0010, 3'b000, 3'b010, 3, 32'h0, 1, 32'hFFFFFF12, 0, 0, 4);
    access("tmo", 1, 0, 32'h104, 32'h0, 4'h0, 3'b000, 3'b000, 0, 32'h0, 1, 32'h00000000, 1, 0, 5);
    access("ackl",1, 0, 32'h108, 32'h0, 4'h0, 3'b000, 3'b000, 4, 32'h12345678, 1, 32'h12345678, 0, 0, 5);
    access("rw",  1, 1, 32'h10C, 32'hCAFEF00D, 4'hF, 3'b000, 3'b000, 1, 32'h0, 1, 32'h12345678, 0, 0, 2);
`ifdef ALIGN_CHECK_EN
    access("mis", 1, 0, 32'h102, 32'h0, 4'h0, 3'b000, 3'b000, 1, 32'hA5A5A5A5, 0, 32'h00000000, 0, 1, 1);
`else
    access("mis", 1, 0, 32'h102, 32'h0, 4'h0, 3'b000, 3'b000, 1, 32'hA5A5A5A5, 1, 32'hA5A5A5A5, 0, 0, 2);
`endif

    // Reset during the second WAIT cycle abandons the request.
    @(negedge clk);
    exmem_mem_r = 1'b1; exmem_alu_res = 32'h300; exmem_load_sel = 3'b000;
    @(posedge clk); #1;
    chk("rstw.req_on", 32'(dmem_req), 32'd1);
    @(negedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk("rstw.req",   32'(dmem_req), 32'd0);
    chk("rstw.addr",  dmem_addr, 32'd0);
    chk("rstw.load",  load_data, 32'd0);
    chk("rstw.be",    32'(dmem_be), 32'd0);
    chk("rstw.stall", 32'(mem_stall), 32'd1);
    @(negedge clk);
    reset = 1'b0; exmem_mem_r = 1'b0;
    #1 chk("rstw.stall_off", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    chk("rstw.idle_req", 32'(dmem_req), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
